// File: rtl/imem_loader_if.sv
// -----------------------------------------------------------------------------
// imem_loader_if
//   Bundles the host byte stream and the instruction RAM write port of the
//   program loader.
//   Byte stream : in_data, in_valid (host -> loader), in_ready (loader -> host)
//   RAM write   : mem_addr, mem_data, mem_wren (loader -> instruction RAM)
//   modport slave  : the loader side (consumes bytes, drives the RAM port)
//   modport master : the host/RAM side (produces bytes, observes the RAM port)
// -----------------------------------------------------------------------------
interface imem_loader_if #(
   parameter int DATA_WIDTH = 32,
   parameter int ADDR_WIDTH = 8
);
   logic [7:0]            in_data;
   logic                  in_valid;
   logic                  in_ready;
   logic [ADDR_WIDTH-1:0] mem_addr;
   logic [DATA_WIDTH-1:0] mem_data;
   logic                  mem_wren;

   modport master (
      output in_data,
      output in_valid,
      input  in_ready,
      input  mem_addr,
      input  mem_data,
      input  mem_wren
   );

   modport slave (
      input  in_data,
      input  in_valid,
      output in_ready,
      output mem_addr,
      output mem_data,
      output mem_wren
   );
endinterface

// File: rtl/imem_loader.sv
// -----------------------------------------------------------------------------
// imem_loader
//   Byte-stream program loader feeding the MIPSCPU instruction RAM.
//   A load is a 16-bit big-endian word count N followed by N big-endian
//   32-bit instructions. Each assembled word is written to RAM address
//   word_cnt. The CPU is held off (cpu_en=0) until the image is complete.
// Ports
//   clk      : system clock, rising edge
//   rst      : asynchronous active-low reset
//   start    : one-cycle pulse that begins a load (only in IDLE/DONE/ERROR)
//   bus      : byte stream in + RAM write port out (imem_loader_if.slave)
//   cpu_en   : high only in DONE
//   busy     : high while a load is in progress (HDR_HI/HDR_LO/PAYLOAD/WRITE)
//   error    : high in ERROR (header larger than RAM capacity)
//   word_cnt : words written so far in the current load
// -----------------------------------------------------------------------------
module imem_loader #(
   parameter int DATA_WIDTH = 32,
   parameter int ADDR_WIDTH = 8
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                start,
   imem_loader_if.slave        bus,
   output logic                cpu_en,
   output logic                busy,
   output logic                error,
   output logic [15:0]         word_cnt
);

   typedef enum logic [2:0] {
      S_IDLE    = 3'd0,
      S_HDR_HI  = 3'd1,
      S_HDR_LO  = 3'd2,
      S_PAYLOAD = 3'd3,
      S_WRITE   = 3'd4,
      S_DONE    = 3'd5,
      S_ERROR   = 3'd6
   } state_t;

   // 17 bits so that a 16-bit address space (65536 words) is still representable
   localparam logic [16:0] CAPACITY = 17'd1 << ADDR_WIDTH;

   state_t                state_r;
   state_t                next_state_s;

   logic [15:0]           n_r;          // header word count
   logic [1:0]            byte_idx_r;   // byte position within current word
   logic [23:0]           word_r;       // first three bytes of the current word
   logic [15:0]           word_cnt_r;
   logic [ADDR_WIDTH-1:0] mem_addr_r;
   logic [DATA_WIDTH-1:0] mem_data_r;
   logic                  mem_wren_r;
   logic                  in_ready_r;
   logic                  cpu_en_r;
   logic                  busy_r;
   logic                  error_r;

   logic                  in_ready_s;
   logic                  cpu_en_s;
   logic                  busy_s;
   logic                  error_s;
   logic                  mem_wren_s;

   logic                  accept_s;
   logic                  start_load_s;
   logic [15:0]           hdr_n_s;
   logic                  last_word_s;
   logic                  word_full_s;

   // in_ready_r always mirrors the ready decode of state_r, so it gates acceptance
   assign accept_s     = bus.in_valid & in_ready_r;
   assign start_load_s = start & ((state_r == S_IDLE) | (state_r == S_DONE) | (state_r == S_ERROR));
   assign hdr_n_s      = {n_r[15:8], bus.in_data};
   assign last_word_s  = ((word_cnt_r + 16'd1) == n_r);
   assign word_full_s  = accept_s & (state_r == S_PAYLOAD) & (byte_idx_r == 2'd3);

   // State register
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_r <= S_IDLE;
      end else begin
         state_r <= next_state_s;
      end
   end

   // Next-state logic
   always_comb begin
      next_state_s = state_r;
      case (state_r)
         S_IDLE: begin
            if (start) next_state_s = S_HDR_HI;
            else       next_state_s = S_IDLE;
         end
         S_HDR_HI: begin
            if (accept_s) next_state_s = S_HDR_LO;
            else          next_state_s = S_HDR_HI;
         end
         S_HDR_LO: begin
            if (!accept_s)                         next_state_s = S_HDR_LO;
            else if (hdr_n_s == 16'd0)             next_state_s = S_DONE;
            else if ({1'b0, hdr_n_s} > CAPACITY)   next_state_s = S_ERROR;
            else                                   next_state_s = S_PAYLOAD;
         end
         S_PAYLOAD: begin
            if (word_full_s) next_state_s = S_WRITE;
            else             next_state_s = S_PAYLOAD;
         end
         S_WRITE: begin
            if (last_word_s) next_state_s = S_DONE;
            else             next_state_s = S_PAYLOAD;
         end
         S_DONE: begin
            if (start) next_state_s = S_HDR_HI;
            else       next_state_s = S_DONE;
         end
         S_ERROR: begin
            if (start) next_state_s = S_HDR_HI;
            else       next_state_s = S_ERROR;
         end
         default: next_state_s = S_IDLE;
      endcase
   end

   // Output decode of the upcoming state; registered below so outputs line up with state_r
   always_comb begin
      in_ready_s = 1'b0;
      cpu_en_s   = 1'b0;
      busy_s     = 1'b0;
      error_s    = 1'b0;
      mem_wren_s = 1'b0;
      case (next_state_s)
         S_HDR_HI, S_HDR_LO, S_PAYLOAD: begin
            in_ready_s = 1'b1;
            busy_s     = 1'b1;
         end
         S_WRITE: begin
            busy_s     = 1'b1;
            mem_wren_s = 1'b1;
         end
         S_DONE:  cpu_en_s = 1'b1;
         S_ERROR: error_s  = 1'b1;
         default: begin
            in_ready_s = 1'b0;
            cpu_en_s   = 1'b0;
            busy_s     = 1'b0;
            error_s    = 1'b0;
            mem_wren_s = 1'b0;
         end
      endcase
   end

   // Status/strobe output registers
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         in_ready_r <= 1'b0;
         cpu_en_r   <= 1'b0;
         busy_r     <= 1'b0;
         error_r    <= 1'b0;
         mem_wren_r <= 1'b0;
      end else begin
         in_ready_r <= in_ready_s;
         cpu_en_r   <= cpu_en_s;
         busy_r     <= busy_s;
         error_r    <= error_s;
         mem_wren_r <= mem_wren_s;
      end
   end

   // Header capture, word assembly and word counting
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         n_r        <= 16'd0;
         byte_idx_r <= 2'd0;
         word_r     <= 24'd0;
         word_cnt_r <= 16'd0;
      end else if (start_load_s) begin
         n_r        <= 16'd0;
         byte_idx_r <= 2'd0;
         word_r     <= 24'd0;
         word_cnt_r <= 16'd0;
      end else if (accept_s) begin
         case (state_r)
            S_HDR_HI: n_r[15:8] <= bus.in_data;
            S_HDR_LO: n_r[7:0]  <= bus.in_data;
            S_PAYLOAD: begin
               // shift in MSB first; byte_idx wraps 3 -> 0 on its own
               word_r     <= {word_r[15:0], bus.in_data};
               byte_idx_r <= byte_idx_r + 2'd1;
            end
            default: n_r <= n_r;
         endcase
      end else if (state_r == S_WRITE) begin
         word_cnt_r <= word_cnt_r + 16'd1;
      end else begin
         word_cnt_r <= word_cnt_r;
      end
   end

   // RAM address/data registers; they only change when a word completes and hold otherwise
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         mem_addr_r <= '0;
         mem_data_r <= '0;
      end else if (word_full_s) begin
         mem_addr_r <= word_cnt_r[ADDR_WIDTH-1:0];
         mem_data_r <= {word_r, bus.in_data};
      end else begin
         mem_addr_r <= mem_addr_r;
         mem_data_r <= mem_data_r;
      end
   end

   assign bus.in_ready = in_ready_r;
   assign bus.mem_addr = mem_addr_r;
   assign bus.mem_data = mem_data_r;
   assign bus.mem_wren = mem_wren_r;
   assign cpu_en       = cpu_en_r;
   assign busy         = busy_r;
   assign error        = error_r;
   assign word_cnt     = word_cnt_r;

endmodule

// File: tb/tb_imem_loader.sv
// -----------------------------------------------------------------------------
// tb_imem_loader
//   Directed bench for imem_loader: normal load, empty image, oversize header,
//   full-capacity load, stalled stream, reset mid-load and reload from DONE.
//   A small RAM model captures every write strobe; inputs change on the
//   falling edge and outputs are sampled there too.
// -----------------------------------------------------------------------------
module tb_imem_loader;
   localparam int AW = 8;

   logic        clk   = 1'b0;
   logic        rst   = 1'b0;
   logic        start = 1'b0;
   logic        cpu_en;
   logic        busy;
   logic        error;
   logic [15:0] word_cnt;

   int n_checks = 0;
   int n_errors = 0;

   imem_loader_if #(.DATA_WIDTH(32), .ADDR_WIDTH(AW)) bus ();

   imem_loader #(.DATA_WIDTH(32), .ADDR_WIDTH(AW)) dut (
      .clk      (clk),
      .rst      (rst),
      .start    (start),
      .bus      (bus),
      .cpu_en   (cpu_en),
      .busy     (busy),
      .error    (error),
      .word_cnt (word_cnt)
   );

   always #5 clk = ~clk;

   // RAM model and write-cycle monitor
   logic [31:0] ram [0:255];
   int wren_cnt   = 0;
   int ready_viol = 0;

   always @(negedge clk) begin
      if (bus.mem_wren === 1'b1) begin
         ram[bus.mem_addr] = bus.mem_data;
         wren_cnt++;
         if (bus.in_ready !== 1'b0) ready_viol++;
      end
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic send_byte(input logic [7:0] b);
      bit done;
      done = 1'b0;
      bus.in_valid = 1'b1;
      bus.in_data  = b;
      for (int k = 0; k < 50 && !done; k++) begin
         if (bus.in_ready === 1'b1) done = 1'b1;
         @(negedge clk);
      end
      bus.in_valid = 1'b0;
      if (!done) begin
         n_checks++;
         n_errors++;
         $error("FAIL accept_timeout: byte %h never accepted", b);
      end
   endtask

   task automatic send_word(input logic [31:0] w, input int max_gap);
      for (int i = 0; i < 4; i++) begin
         repeat ($urandom_range(0, max_gap)) @(negedge clk);
         send_byte(w[31-8*i -: 8]);
      end
   endtask

   task automatic pulse_start();
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
   endtask

   task automatic wait_cpu_en();
      bit seen;
      seen = 1'b0;
      for (int k = 0; k < 20 && !seen; k++) begin
         if (cpu_en === 1'b1) seen = 1'b1;
         else @(negedge clk);
      end
      if (!seen) begin
         n_checks++;
         n_errors++;
         $error("FAIL cpu_en_timeout: cpu_en never rose");
      end
   endtask

   function automatic logic [31:0] word_pat(input int i);
      logic [7:0] b;
      b = i[7:0];
      return {8'hA5, b, ~b, 8'h3C};
   endfunction

   initial begin
      int w0;
      bus.in_valid = 1'b0;
      bus.in_data  = 8'h00;

      // ---------------- reset state ----------------
      repeat (3) @(negedge clk);
      chk("rst_in_ready", bus.in_ready, 1'b0);
      chk("rst_mem_addr", bus.mem_addr, 8'h00);
      chk("rst_mem_data", bus.mem_data, 32'h0);
      chk("rst_mem_wren", bus.mem_wren, 1'b0);
      chk("rst_cpu_en",   cpu_en,       1'b0);
      chk("rst_busy",     busy,         1'b0);
      chk("rst_error",    error,        1'b0);
      chk("rst_word_cnt", word_cnt,     16'd0);
      rst = 1'b1;
      @(negedge clk);

      // ---------------- 1: two-word load ----------------
      pulse_start();
      chk("t1_busy_hdr",  busy,         1'b1);
      chk("t1_ready_hdr", bus.in_ready, 1'b1);
      send_byte(8'h00); send_byte(8'h02);
      send_word(32'h24080005, 0);
      chk("t1_lat_wren",  bus.mem_wren, 1'b1);
      chk("t1_lat_addr",  bus.mem_addr, 8'h00);
      chk("t1_lat_data",  bus.mem_data, 32'h24080005);
      chk("t1_lat_ready", bus.in_ready, 1'b0);
      chk("t1_lat_cpu",   cpu_en,       1'b0);
      send_word(32'h00000008, 0);
      wait_cpu_en();
      chk("t1_ram0",      ram[0],       32'h24080005);
      chk("t1_ram1",      ram[1],       32'h00000008);
      chk("t1_word_cnt",  word_cnt,     16'd2);
      chk("t1_cpu_en",    cpu_en,       1'b1);
      chk("t1_busy",      busy,         1'b0);
      chk("t1_wren_hold", bus.mem_wren, 1'b0);
      chk("t1_addr_hold", bus.mem_addr, 8'h01);
      chk("t1_data_hold", bus.mem_data, 32'h00000008);
      chk("t1_wren_cnt",  wren_cnt,     32'd2);

      // ---------------- 2: empty image ----------------
      w0 = wren_cnt;
      pulse_start();
      chk("t2_cpu_fall",  cpu_en,       1'b0);
      send_byte(8'h00); send_byte(8'h00);
      chk("t2_cpu_en",    cpu_en,       1'b1);
      chk("t2_busy",      busy,         1'b0);
      chk("t2_word_cnt",  word_cnt,     16'd0);
      chk("t2_no_wren",   wren_cnt,     w0);

      // ---------------- 3: oversize header, then full capacity ----------------
      pulse_start();
      send_byte(8'h01); send_byte(8'h01);
      chk("t3_error",     error,        1'b1);
      chk("t3_cpu_en",    cpu_en,       1'b0);
      chk("t3_in_ready",  bus.in_ready, 1'b0);
      chk("t3_busy",      busy,         1'b0);
      bus.in_valid = 1'b1;
      bus.in_data  = 8'hAA;
      repeat (3) @(negedge clk);
      bus.in_valid = 1'b0;
      chk("t3_err_hold",  error,        1'b1);
      pulse_start();
      chk("t3_err_clr",   error,        1'b0);
      chk("t3_busy_re",   busy,         1'b1);
      chk("t3_ready_re",  bus.in_ready, 1'b1);
      w0 = wren_cnt;
      send_byte(8'h01); send_byte(8'h00);
      for (int i = 0; i < 256; i++) send_word(word_pat(i), 0);
      wait_cpu_en();
      chk("t3_full_cnt",  word_cnt,     16'd256);
      chk("t3_full_addr", bus.mem_addr, 8'hFF);
      chk("t3_ram0",      ram[0],       32'hA500FF3C);
      chk("t3_ram128",    ram[128],     32'hA5807F3C);
      chk("t3_ram255",    ram[255],     32'hA5FF003C);
      chk("t3_wrens",     wren_cnt - w0, 32'd256);
      chk("t3_error_off", error,        1'b0);

      // ---------------- 4: stalled stream ----------------
      w0 = wren_cnt;
      ready_viol = 0;
      pulse_start();
      send_byte(8'h00); send_byte(8'h04);
      send_word(32'h11223344, 3);
      send_word(32'h55667788, 3);
      send_word(32'h99AABBCC, 3);
      send_word(32'hDDEEFF00, 3);
      wait_cpu_en();
      chk("t4_ram0",      ram[0],       32'h11223344);
      chk("t4_ram1",      ram[1],       32'h55667788);
      chk("t4_ram2",      ram[2],       32'h99AABBCC);
      chk("t4_ram3",      ram[3],       32'hDDEEFF00);
      chk("t4_ram4_keep", ram[4],       32'hA504FB3C);
      chk("t4_word_cnt",  word_cnt,     16'd4);
      chk("t4_wrens",     wren_cnt - w0, 32'd4);
      chk("t4_ready_viol", ready_viol,  32'd0);

      // ---------------- 5: reset mid-word, then simultaneous start/valid ----------------
      pulse_start();
      send_byte(8'h00); send_byte(8'h03);
      send_word(32'h01020304, 0);
      send_byte(8'h05); send_byte(8'h06);
      #1 rst = 1'b0;
      #1;
      chk("t5_in_ready",  bus.in_ready, 1'b0);
      chk("t5_mem_addr",  bus.mem_addr, 8'h00);
      chk("t5_mem_data",  bus.mem_data, 32'h0);
      chk("t5_mem_wren",  bus.mem_wren, 1'b0);
      chk("t5_cpu_en",    cpu_en,       1'b0);
      chk("t5_busy",      busy,         1'b0);
      chk("t5_error",     error,        1'b0);
      chk("t5_word_cnt",  word_cnt,     16'd0);
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      start = 1'b1;
      bus.in_valid = 1'b1;
      bus.in_data  = 8'hFF;
      @(negedge clk);
      start = 1'b0;
      bus.in_valid = 1'b0;
      chk("t5_st_busy",   busy,         1'b1);
      chk("t5_st_ready",  bus.in_ready, 1'b1);
      send_byte(8'h00); send_byte(8'h03);
      send_word(32'hA1A2A3A4, 0);
      send_word(32'hB1B2B3B4, 0);
      send_word(32'hC1C2C3C4, 0);
      wait_cpu_en();
      chk("t5_ram0",      ram[0],       32'hA1A2A3A4);
      chk("t5_ram1",      ram[1],       32'hB1B2B3B4);
      chk("t5_ram2",      ram[2],       32'hC1C2C3C4);
      chk("t5_word_cnt2", word_cnt,     16'd3);
      chk("t5_err2",      error,        1'b0);

      // ---------------- 6: reload from DONE, start ignored mid-load ----------------
      pulse_start();
      chk("t6_cpu_fall",  cpu_en,       1'b0);
      send_byte(8'h00); send_byte(8'h01);
      send_byte(8'hDE); send_byte(8'hAD);
      pulse_start();
      chk("t6_busy_mid",  busy,         1'b1);
      chk("t6_ready_mid", bus.in_ready, 1'b1);
      send_byte(8'hBE); send_byte(8'hEF);
      chk("t6_wren",      bus.mem_wren, 1'b1);
      chk("t6_data",      bus.mem_data, 32'hDEADBEEF);
      wait_cpu_en();
      chk("t6_ram0",      ram[0],       32'hDEADBEEF);
      chk("t6_word_cnt",  word_cnt,     16'd1);
      chk("t6_cpu_en",    cpu_en,       1'b1);
      chk("t6_error",     error,        1'b0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end
endmodule
